bin_level_mapper: RTL and testbench
===================================

Name: bin_level_mapper

Overview:
- Sits between the sliding-DFT bin output and the dual-port frequency BRAM that feeds the waterfall frame buffer.
- Per bin it applies fast-attack / slow-decay smoothing, using an internal history RAM with one entry per bin.
- It then compresses the smoothed 16-bit magnitude to an 8-bit gradient index with a log2 approximation.
- Replaces the plain truncation of bin data into the BRAM, giving usable dynamic range on the display.

Parameters:
- FREQ_W, 16: input bin width; unsigned; must be ≤16.
- DATA_W, 8: output level width; fixed at 8 when LOG_MAP_EN is defined.
- ADDR_W, 9: bin address width.
- LIMIT_BINS, 320: number of bins tracked; history RAM depth.
- DECAY_SHIFT, 3: decay rate; each falling update removes (old-new)>>DECAY_SHIFT.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  bin sample present.
- in_addr  in  ADDR_W  bin index.
- in_bin  in  FREQ_W  bin magnitude, unsigned.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  one-cycle strobe; drives the BRAM write enable.
- out_addr  out  ADDR_W  BRAM write address.
- out_level  out  DATA_W  BRAM write data.
- err_addr  out  1  sticky flag: an out-of-range address was received.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_addr=0, out_level=0, in_ready=0, err_addr=0; all pipeline valids cleared; FSM enters CLEAR.
- Reset asserted mid-operation: in-flight samples are discarded and CLEAR restarts.
- FSM CLEAR:
  - Writes 0 to history addresses 0..LIMIT_BINS-1, one per cycle.
  - in_ready=0 throughout.
  - After writing address LIMIT_BINS-1, moves to RUN on the next cycle.
- FSM RUN:
  - in_ready=1.
  - A transfer happens when in_valid&in_ready.
- Pipeline, one accept per cycle, fully pipelined:
  - S0: register addr/bin; issue history read at in_addr.
  - S1: history data available. Forwarding: if S2 is writing the same addr this cycle, use the S2 result instead of RAM data.
  - S2: smoothed value s. If new ≥ old, s=new (attack). Else s=old-((old-new)>>DECAY_SHIFT). Write s back to history. No overflow is possible; width stays FREQ_W.
  - S3: out_valid=1, out_addr=addr, out_level=map(s).
- Latency: out_valid rises exactly 3 cycles after the accepting edge; back-to-back inputs give back-to-back outputs.
- Range check: in_addr ≥ LIMIT_BINS is accepted but dropped. It produces no history access and no out_valid, and sets err_addr=1 until reset.
- Log map (LOG_MAP_EN):
  - s=0 → 0.
  - Otherwise p = index of the leading one (0..15).
  - m = the 4 bits directly below the leading one, zero-filled on the right when p<4.
  - level={p[3:0],m[3:0]}. Monotonic non-decreasing in s.
- No backpressure from downstream; the BRAM write port is always ready.

Optional Feature:
- Macro: LOG_MAP_EN.
- Defined: log map as above.
- Undefined: linear map, out_level = s[FREQ_W-1 -: DATA_W]. DATA_W may be any value ≤FREQ_W. Pipeline latency unchanged: S3 is still registered.

Decomposition:
- Package bin_map_pkg holds:
  - the FSM state enum (CLEAR, RUN);
  - the pipeline stage count constant (3);
  - the log mantissa width constant (4).
- Sub-module log2_level_map: combinational leading-one detect plus mantissa extraction, instantiated once in S3; output registered by the parent.

Test Plan:
- Reset then idle: in_ready=0 for exactly 320 cycles after reset deasserts, then 1; no out_valid during CLEAR.
- Attack plus log: addr 5, bin 0x0400 → 3 cycles later out_valid=1, out_addr=5, out_level=0xA0. Bin 0xFFFF → 0xFF. Bin 0x0001 → 0x00; bin 0x0000 → 0x00.
- Decay: addr 7 fed 0x8000, then 0x0000 five times (DECAY_SHIFT=3) → history 0x8000, 0x7000, 0x6200, 0x55C0, 0x4B08, 0x41A7; out_levels follow the map of each value.
- Forwarding: addr 9 fed 0x1000 then 0x0000 on consecutive cycles → second output reflects s=0x0E00, not the value derived from a stale 0.
- Out-of-range: in_addr=320 → no out_valid, err_addr=1 and stays set; next valid addr processes normally.
- Mid-op reset: assert reset with 3 samples in flight → out_valid stays 0, CLEAR reruns, history reads back 0 (a bin 0 input yields level 0).

Source files
------------

// File: rtl/bin_map_pkg.sv
// Shared types and constants for the bin level mapper: FSM states, pipeline
// depth and log-map mantissa width.
package bin_map_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int PIPE_STAGES = 3;
   localparam int LOG_MANT_W  = 4;

endpackage

// File: rtl/bin_level_mapper_if.sv
// Bin-in / BRAM-write-out bundle for bin_level_mapper, plus sticky error and
// FSM state visibility. slave = mapper side, master = upstream/bench side.
interface bin_level_mapper_if
   import bin_map_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int FREQ_W = 16,
   parameter int DATA_W = 8
);

   // Handshake: a sample transfers on a rising clk edge where in_valid and
   // in_ready are both high; in_addr/in_bin must be stable while in_valid is
   // high. out_valid is a one-cycle strobe with no backpressure (the BRAM
   // write port always accepts).
   logic              in_valid;
   logic [ADDR_W-1:0] in_addr;
   logic [FREQ_W-1:0] in_bin;
   logic              in_ready;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_level;
   logic              err_addr;
   state_t            dbg_state;

   modport slave (
      input  in_valid, in_addr, in_bin,
      output in_ready, out_valid, out_addr, out_level, err_addr, dbg_state
   );

   modport master (
      output in_valid, in_addr, in_bin,
      input  in_ready, out_valid, out_addr, out_level, err_addr, dbg_state
   );

endinterface

// File: rtl/log2_level_map.sv
// Combinational magnitude-to-level map. With LOG_MAP_EN defined: leading-one
// exponent plus 4-bit mantissa; otherwise the top DATA_W bits of the input.
module log2_level_map #(
   parameter int FREQ_W = 16,
   parameter int DATA_W = 8
) (
   input  logic [FREQ_W-1:0] s_i,
   output logic [DATA_W-1:0] level_o
);

`ifdef LOG_MAP_EN
   localparam int MW = bin_map_pkg::LOG_MANT_W;

   logic [3:0]           p;
   logic [FREQ_W+MW-1:0] t;
   logic [MW-1:0]        m;

   always_comb begin
      p = '0;
      for (int i = 0; i < FREQ_W; i++) begin
         if (s_i[i]) p = 4'(i);
      end
   end

   // Padding MW zeros on the right makes the bits below the leading one
   // land at t[p +: MW], zero-filled when p < MW.
   assign t = {s_i, {MW{1'b0}}};
   assign m = t[p +: MW];

   always_comb begin
      if (s_i == '0) level_o = '0;
      else           level_o = DATA_W'({p, m});
   end
`else
   assign level_o = s_i[FREQ_W-1 -: DATA_W];
`endif

endmodule

// File: rtl/bin_level_mapper.sv
// Per-bin fast-attack/slow-decay smoothing with a history RAM, then level
// compression into the waterfall BRAM. Optional macro: LOG_MAP_EN (log map).
module bin_level_mapper
   import bin_map_pkg::*;
#(
   parameter int FREQ_W      = 16,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 9,
   parameter int LIMIT_BINS  = 320,
   parameter int DECAY_SHIFT = 3
) (
   input logic              clk,
   input logic              reset,
   bin_level_mapper_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LIMIT_BINS - 1);

   function automatic logic [FREQ_W-1:0] smooth(input logic [FREQ_W-1:0] old_v,
                                                input logic [FREQ_W-1:0] new_v);
      if (new_v >= old_v) return new_v;
      return old_v - ((old_v - new_v) >> DECAY_SHIFT);
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              clr_we;
   logic              in_ready;

   logic              s0_valid_q, s1_valid_q, s2_valid_q;
   logic [ADDR_W-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
   logic [FREQ_W-1:0] s0_bin_q, s1_bin_q;
   logic [FREQ_W-1:0] rd_q, s1_old_q, s2_s_q;
   logic [FREQ_W-1:0] old_fwd, s_new;

   logic              out_valid_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_level_q;
   logic [DATA_W-1:0] level;
   logic              err_q;

   logic [FREQ_W-1:0] hist_mem [LIMIT_BINS];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [FREQ_W-1:0] mem_wd;

   logic in_range, acc_ok, acc_bad;

   assign in_range = ({1'b0, bus.in_addr} < (ADDR_W + 1)'(LIMIT_BINS));
   assign acc_ok   = bus.in_valid & in_ready & in_range;
   assign acc_bad  = bus.in_valid & in_ready & ~in_range;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = RUN;
               clr_cnt_d = '0;
            end
         end
         RUN:     in_ready = 1'b1;
         default: state_d  = CLEAR;
      endcase
   end

   // A read issued in S0 can miss a write from either of the two older
   // samples still in flight; the youngest matching writer wins.
   always_comb begin
      old_fwd = rd_q;
      if (s1_valid_q && (s1_addr_q == s0_addr_q))      old_fwd = s_new;
      else if (s2_valid_q && (s2_addr_q == s0_addr_q)) old_fwd = s2_s_q;
   end

   assign s_new = smooth(s1_old_q, s1_bin_q);

   always_comb begin
      mem_we = clr_we | s1_valid_q;
      mem_wa = clr_we ? clr_cnt_q : s1_addr_q;
      mem_wd = clr_we ? '0 : s_new;
   end

   always_ff @(posedge clk) begin
      if (mem_we) hist_mem[mem_wa] <= mem_wd;
   end

   log2_level_map #(.FREQ_W(FREQ_W), .DATA_W(DATA_W)) u_map (
      .s_i     (s2_s_q),
      .level_o (level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s0_addr_q   <= '0;
         s1_addr_q   <= '0;
         s2_addr_q   <= '0;
         s0_bin_q    <= '0;
         s1_bin_q    <= '0;
         rd_q        <= '0;
         s1_old_q    <= '0;
         s2_s_q      <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_level_q <= '0;
         err_q       <= 1'b0;
      end else begin
         s0_valid_q <= acc_ok;
         if (acc_ok) begin
            s0_addr_q <= bus.in_addr;
            s0_bin_q  <= bus.in_bin;
            rd_q      <= hist_mem[bus.in_addr];
         end
         s1_valid_q <= s0_valid_q;
         if (s0_valid_q) begin
            s1_addr_q <= s0_addr_q;
            s1_bin_q  <= s0_bin_q;
            s1_old_q  <= old_fwd;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_addr_q <= s1_addr_q;
            s2_s_q    <= s_new;
         end
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_addr_q  <= s2_addr_q;
            out_level_q <= level;
         end
         err_q <= err_q | acc_bad;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_level = out_level_q;
   assign bus.err_addr  = err_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bin_level_mapper.sv
// Directed bench for bin_level_mapper: clear timing, attack/decay smoothing,
// forwarding, range errors and mid-operation reset. Levels track LOG_MAP_EN.
module tb_bin_level_mapper;
   import bin_map_pkg::*;

   localparam int ADDR_W = 9;
   localparam int FREQ_W = 16;
   localparam int DATA_W = 8;
   localparam int EW     = 32 + ADDR_W + DATA_W;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Each entry: {cycle the output must appear, addr, level}.
   logic [EW-1:0] exp_q[$];

   bin_level_mapper_if #(.ADDR_W(ADDR_W), .FREQ_W(FREQ_W), .DATA_W(DATA_W)) bus ();

   bin_level_mapper #(
      .FREQ_W(FREQ_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .LIMIT_BINS(320), .DECAY_SHIFT(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pick(input logic [7:0] log_v, input logic [7:0] lin_v);
`ifdef LOG_MAP_EN
      return log_v;
`else
      return lin_v;
`endif
   endfunction

   // Driver: present one sample for one edge; optionally expect its output.
   task automatic send(input logic [ADDR_W-1:0] a, input logic [FREQ_W-1:0] b,
                       input logic push, input logic [DATA_W-1:0] lvl);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_bin   = b;
      check("in_ready_at_send", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (push) exp_q.push_back({32'(cyc + 3), a, lvl});
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 32'(n), 32'd320);
   endtask

   // Scoreboard: every out_valid must match the head of exp_q, on time.
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_cycle", 32'(cyc), e[EW-1 -: 32]);
               check("out_addr", 32'(bus.out_addr), 32'(e[DATA_W +: ADDR_W]));
               check("out_level", 32'(bus.out_level), 32'(e[DATA_W-1:0]));
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_bin   = '0;

      // Reset state and clear sweep.
      reset = 1'b1;
      idle(3);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), 32'd0);
      check("rst_out_level", 32'(bus.out_level), 32'd0);
      check("rst_err_addr", 32'(bus.err_addr), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(CLEAR));
      reset = 1'b0;
      wait_ready("clear_cycles");
      check("run_state", 32'(bus.dbg_state), 32'(RUN));

      // Attack and map points on fresh bins.
      send(9'd5,  16'h0400, 1'b1, pick(8'hA0, 8'h04));
      send(9'd6,  16'hFFFF, 1'b1, pick(8'hFF, 8'hFF));
      send(9'd10, 16'h0001, 1'b1, pick(8'h00, 8'h00));
      send(9'd11, 16'h0000, 1'b1, pick(8'h00, 8'h00));
      send(9'd13, 16'h0005, 1'b1, pick(8'h24, 8'h00));
      send(9'd14, 16'h00C3, 1'b1, pick(8'h78, 8'h00));
      drain();

      // Decay chain on addr 7, back-to-back.
      send(9'd7, 16'h8000, 1'b1, pick(8'hF0, 8'h80));
      send(9'd7, 16'h0000, 1'b1, pick(8'hEC, 8'h70));
      send(9'd7, 16'h0000, 1'b1, pick(8'hE8, 8'h62));
      send(9'd7, 16'h0000, 1'b1, pick(8'hE5, 8'h55));
      send(9'd7, 16'h0000, 1'b1, pick(8'hE2, 8'h4B));
      send(9'd7, 16'h0000, 1'b1, pick(8'hE0, 8'h41));
      drain();

      // Forwarding: adjacent and one-gap repeats of the same bin.
      send(9'd9, 16'h1000, 1'b1, pick(8'hC0, 8'h10));
      send(9'd9, 16'h0000, 1'b1, pick(8'hBC, 8'h0E));
      send(9'd12, 16'h2000, 1'b1, pick(8'hD0, 8'h20));
      idle(1);
      send(9'd12, 16'h0000, 1'b1, pick(8'hCC, 8'h1C));
      drain();

      // Out-of-range address is dropped and latches the error.
      check("err_before", 32'(bus.err_addr), 32'd0);
      send(9'd320, 16'h1111, 1'b0, 8'h00);
      check("err_set", 32'(bus.err_addr), 32'd1);
      idle(5);
      check("err_sticky", 32'(bus.err_addr), 32'd1);
      send(9'd3, 16'h0400, 1'b1, pick(8'hA0, 8'h04));
      drain();
      check("err_still_set", 32'(bus.err_addr), 32'd1);

      // Reset with three samples in flight.
      send(9'd20, 16'h1234, 1'b0, 8'h00);
      send(9'd21, 16'h4321, 1'b0, 8'h00);
      send(9'd22, 16'h0F0F, 1'b0, 8'h00);
      reset = 1'b1;
      idle(1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_err_clear", 32'(bus.err_addr), 32'd0);
      idle(1);
      reset = 1'b0;
      wait_ready("reclear_cycles");
      send(9'd20, 16'h0000, 1'b1, pick(8'h00, 8'h00));
      send(9'd21, 16'h0000, 1'b1, pick(8'h00, 8'h00));
      drain();

      idle(4);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
